aha_loop_back_monitor: RTL and testbench

AHA_LOOP_BACK_MONITOR -- requirements
Module: aha_loop_back_monitor

---
 rtl/aha_loop_back_monitor.sv | 148 ++++++++++++++
 tb/tb_aha_loop_back_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aha_loop_back_monitor.sv
// Loop-back monitor: synchronizes a returned loop-back signal and counts its
// rising edges over a programmable window of CLK cycles.
//
// Handshake: START is a request sampled only while idle (BUSY=0); WINDOW is
// captured in the same cycle. The result on EDGE_COUNT/OVERFLOW is valid
// when DONE pulses for one cycle, and it is held until the next DONE or reset.
// A zero-length window completes immediately, without entering MEASURE.
// BUSY reflects the FSM state directly (MEASURE) and doubles as its debug view.
module aha_loop_back_monitor #(
    parameter int CNT_WIDTH = 16,
    parameter int WIN_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LOOP_BACK_IN,
    input  logic                 START,
    input  logic [WIN_WIDTH-1:0] WINDOW,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CNT_WIDTH-1:0] EDGE_COUNT,
    output logic                 OVERFLOW,
    output logic                 LEVEL
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ACC_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ACC_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIN_WIDTH-1:0] WIN_ONE = {{(WIN_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_next;
    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic                 rise;
    logic [WIN_WIDTH-1:0] win_cnt;
    logic [WIN_WIDTH-1:0] win_cnt_next;
    logic [CNT_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0] acc_inc;
    logic                 ovf;
    logic                 ovf_next;
    logic                 ovf_inc;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 result_ovf_next;
    logic                 done_next;

    // Two-flop synchronizer plus one history flop for edge detection.
    // s3 resets to 0, so a line already high at reset release counts once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= LOOP_BACK_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise  = s2 & ~s3;
    assign LEVEL = s2;
    assign BUSY  = (state == MEASURE);

    // Saturating accumulate of this cycle's edge; an edge at saturation flags overflow.
    always_comb begin
        acc_inc = acc;
        ovf_inc = ovf;
        if (rise) begin
            if (acc == ACC_MAX) begin
                ovf_inc = 1'b1;
            end else begin
                acc_inc = acc + ACC_ONE;
            end
        end
    end

    // Next-state and datapath updates for the IDLE/MEASURE controller.
    always_comb begin
        state_next      = state;
        win_cnt_next    = win_cnt;
        acc_next        = acc;
        ovf_next        = ovf;
        count_next      = EDGE_COUNT;
        result_ovf_next = OVERFLOW;
        done_next       = 1'b0;
        if (state == IDLE) begin
            if (START) begin
                if (WINDOW != '0) begin
                    // The accept-cycle edge is discarded by clearing here.
                    win_cnt_next = WINDOW;
                    acc_next     = '0;
                    ovf_next     = 1'b0;
                    state_next   = MEASURE;
                end else begin
                    count_next      = '0;
                    result_ovf_next = 1'b0;
                    done_next       = 1'b1;
                end
            end
        end else begin
            win_cnt_next = win_cnt - WIN_ONE;
            acc_next     = acc_inc;
            ovf_next     = ovf_inc;
            if (win_cnt == WIN_ONE) begin
                // Closing cycle: publish the total including this cycle's edge.
                count_next      = acc_inc;
                result_ovf_next = ovf_inc;
                done_next       = 1'b1;
                state_next      = IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Window counter, accumulator, overflow flag and published result registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            win_cnt    <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            EDGE_COUNT <= '0;
            OVERFLOW   <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            win_cnt    <= win_cnt_next;
            acc        <= acc_next;
            ovf        <= ovf_next;
            EDGE_COUNT <= count_next;
            OVERFLOW   <= result_ovf_next;
            DONE       <= done_next;
        end
    end

endmodule

// File: tb/tb_aha_loop_back_monitor.sv
// Bench for aha_loop_back_monitor: two instances (16-bit and 4-bit counters)
// share all inputs and are checked every cycle against a window-sum model.
module tb_aha_loop_back_monitor;

    localparam int WW = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          LOOP_BACK_IN = 1'b0;
    logic          START = 1'b0;
    logic [WW-1:0] WINDOW = '0;

    logic          busy_a, done_a, ovf_a, level_a;
    logic [15:0]   cnt_a;
    logic          busy_b, done_b, ovf_b, level_b;
    logic [3:0]    cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    aha_loop_back_monitor #(.CNT_WIDTH(16), .WIN_WIDTH(WW)) dut_a (
        .CLK(CLK), .RESET(RESET), .LOOP_BACK_IN(LOOP_BACK_IN), .START(START),
        .WINDOW(WINDOW), .BUSY(busy_a), .DONE(done_a), .EDGE_COUNT(cnt_a),
        .OVERFLOW(ovf_a), .LEVEL(level_a)
    );

    aha_loop_back_monitor #(.CNT_WIDTH(4), .WIN_WIDTH(WW)) dut_b (
        .CLK(CLK), .RESET(RESET), .LOOP_BACK_IN(LOOP_BACK_IN), .START(START),
        .WINDOW(WINDOW), .BUSY(busy_b), .DONE(done_b), .EDGE_COUNT(cnt_b),
        .OVERFLOW(ovf_b), .LEVEL(level_b)
    );

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- loop-back input driver ----------------
    // mode 0: static level, 1: square wave of in_period cycles, 2: random
    int   in_mode = 0;
    int   in_period = 4;
    int   ph = 0;
    logic in_static = 1'b0;

    always @(negedge CLK) begin
        case (in_mode)
            0: LOOP_BACK_IN = in_static;
            1: begin
                ph = (ph + 1) % in_period;
                LOOP_BACK_IN = (ph < in_period / 2);
            end
            default: LOOP_BACK_IN = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- behavioural model ----------------
    // Line history by clock edge; a rise seen at edge m is the input sampled
    // two edges earlier being 1 while three edges earlier was 0. A window
    // result is the plain sum of rises over the W edges after the accept edge,
    // clipped to the counter maximum, with overflow meaning the sum exceeded it.
    int   cyc = 0;
    logic h0 = 0, h1 = 0, h2 = 0;
    logic m_busy = 0;
    int   m_end = 0;
    int   m_sum = 0;
    logic rise_now;
    logic e_busy = 0, e_done = 0, e_ovf_a = 0, e_ovf_b = 0, e_level = 0;
    int   e_cnt_a = 0, e_cnt_b = 0;

    always @(posedge CLK) begin
        cyc++;
        if (RESET) begin
            h0 = 0; h1 = 0; h2 = 0;
            m_busy = 0; m_sum = 0;
            e_busy = 0; e_done = 0; e_ovf_a = 0; e_ovf_b = 0; e_level = 0;
            e_cnt_a = 0; e_cnt_b = 0;
        end else begin
            rise_now = h1 & ~h2;
            h2 = h1; h1 = h0; h0 = LOOP_BACK_IN;
            e_done = 0;
            if (m_busy) begin
                m_sum += int'(rise_now);
                if (cyc == m_end) begin
                    m_busy  = 0;
                    e_done  = 1;
                    e_cnt_a = (m_sum > 65535) ? 65535 : m_sum;
                    e_ovf_a = (m_sum > 65535);
                    e_cnt_b = (m_sum > 15) ? 15 : m_sum;
                    e_ovf_b = (m_sum > 15);
                end
            end else if (START) begin
                if (WINDOW == '0) begin
                    e_done = 1;
                    e_cnt_a = 0; e_ovf_a = 0;
                    e_cnt_b = 0; e_ovf_b = 0;
                end else begin
                    m_busy = 1;
                    m_end  = cyc + int'(WINDOW);
                    m_sum  = 0;
                end
            end
            e_busy  = m_busy;
            e_level = h1;
        end
    end

    // ---------------- compare process ----------------
    always @(posedge CLK) begin
        #1;
        chk("busy_a", int'(busy_a), int'(e_busy));
        chk("done_a", int'(done_a), int'(e_done));
        chk("count_a", int'(cnt_a), e_cnt_a);
        chk("ovf_a", int'(ovf_a), int'(e_ovf_a));
        chk("level_a", int'(level_a), int'(e_level));
        chk("busy_b", int'(busy_b), int'(e_busy));
        chk("done_b", int'(done_b), int'(e_done));
        chk("count_b", int'(cnt_b), e_cnt_b);
        chk("ovf_b", int'(ovf_b), int'(e_ovf_b));
    end

    // ---------------- driver tasks ----------------
    task automatic start_meas(input int w, output int accept_cyc);
        @(negedge CLK);
        START  = 1'b1;
        WINDOW = WW'(w);
        @(negedge CLK);
        START = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_a) begin
                done_cyc = cyc;
                break;
            end
            @(negedge CLK);
        end
        if (done_cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no DONE within %0d cycles", tag, budget);
        end
    endtask

    task automatic count_dones(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge CLK);
            if (done_a || done_b) c++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy_a | busy_b), 0);
        chk({tag, "_done"}, int'(done_a | done_b), 0);
        chk({tag, "_cnt"}, int'(cnt_a) + int'(cnt_b), 0);
        chk({tag, "_ovf"}, int'(ovf_a | ovf_b), 0);
        chk({tag, "_level"}, int'(level_a | level_b), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int acc_c, dn_c, nd, w, k;
        int d[4];

        repeat (3) @(negedge CLK);
        check_all_zero("reset_init");
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        // Zero window: DONE right after accept, count 0, never busy
        start_meas(0, acc_c);
        chk("zero_done", int'(done_a), 1);
        chk("zero_busy", int'(busy_a), 0);
        chk("zero_cnt", int'(cnt_a), 0);
        count_dones(5, nd);
        chk("zero_single_done", nd, 0);

        // Divided clock: period 4, window 100
        in_mode = 1; in_period = 4;
        repeat (8) @(negedge CLK);
        start_meas(100, acc_c);
        wait_done("div4", 200, dn_c);
        chk("div4_latency", dn_c - acc_c, 100);
        chk("div4_cnt_in_range", int'(cnt_a >= 16'd24 && cnt_a <= 16'd26), 1);
        chk("div4_ovf", int'(ovf_a), 0);

        // Saturation: period 2, window 64 -> 32 edges, 4-bit clips at 15
        in_period = 2;
        repeat (6) @(negedge CLK);
        start_meas(64, acc_c);
        wait_done("sat", 100, dn_c);
        chk("sat_cnt_b", int'(cnt_b), 15);
        chk("sat_ovf_b", int'(ovf_b), 1);
        chk("sat_cnt_a", int'(cnt_a), 32);
        chk("sat_ovf_a", int'(ovf_a), 0);
        in_mode = 0; in_static = 1'b0;
        repeat (6) @(negedge CLK);
        start_meas(30, acc_c);
        wait_done("sat_clear", 60, dn_c);
        chk("sat_clear_cnt_b", int'(cnt_b), 0);
        chk("sat_clear_ovf_b", int'(ovf_b), 0);

        // Ignored START during a window of 50
        in_mode = 2;
        start_meas(50, acc_c);
        repeat (9) @(negedge CLK);
        START = 1'b1; WINDOW = WW'(5);
        @(negedge CLK);
        START = 1'b0; WINDOW = WW'(50);
        wait_done("ignored", 80, dn_c);
        chk("ignored_latency", dn_c - acc_c, 50);
        count_dones(60, nd);
        chk("ignored_single_done", nd, 0);

        // Continuous START with window 20: DONE every 21 cycles
        @(negedge CLK);
        START = 1'b1; WINDOW = WW'(20);
        k = 0;
        for (int i = 0; i < 150 && k < 4; i++) begin
            @(negedge CLK);
            if (done_a) begin
                d[k] = cyc;
                k++;
            end
        end
        START = 1'b0;
        chk("cont_dones_seen", k, 4);
        for (int i = 0; i < 3; i++) chk("cont_period", d[i+1] - d[i], 21);
        repeat (25) @(negedge CLK);

        // Static high level
        in_mode = 0; in_static = 1'b1;
        repeat (6) @(negedge CLK);
        chk("static_level", int'(level_a), 1);
        start_meas(20, acc_c);
        wait_done("static", 40, dn_c);
        chk("static_cnt", int'(cnt_a), 0);

        // Random windows against the model
        in_mode = 2;
        for (int i = 0; i < 25; i++) begin
            w = $urandom_range(0, 90);
            start_meas(w, acc_c);
            wait_done("rand", w + 10, dn_c);
            chk("rand_latency", dn_c - acc_c, w);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        // Reset mid-measurement: immediate zeros, no DONE afterwards
        start_meas(50, acc_c);
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check_all_zero("reset_mid");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        count_dones(70, nd);
        chk("reset_no_done", nd, 0);

        // Line already high at reset release counts as one edge
        @(negedge CLK);
        RESET = 1'b1;
        in_mode = 0; in_static = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        start_meas(10, acc_c);
        wait_done("release_edge", 20, dn_c);
        chk("release_edge_cnt", int'(cnt_a), 1);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
